// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the framebuffer scanout path.
// The colour-bar helper is used only when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int FB_W  = 80;
  localparam int FB_H  = 60;
  localparam int FB_AW = 13;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    rgb_t rgb;
  } vga_out_t;

  // Bars run white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.red   = {4{~idx[1]}};
    c.green = {4{~idx[2]}};
    c.blue  = {4{~idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and stage-S0 sync/visible/frame-start decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          vis,
  output logic          hs,
  output logic          vs,
  output logic          fs
);

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign vis = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign fs  = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer reader and VGA raster generator with a fixed two-clock pipeline.
// Define VGA_TEST_PATTERN_EN to add the i_testPat colour-bar override.
module vga_scanout #(
  parameter int   H_ACTIVE  = vga_pkg::DEF_H_ACTIVE,
  parameter int   H_FP      = vga_pkg::DEF_H_FP,
  parameter int   H_SYNC    = vga_pkg::DEF_H_SYNC,
  parameter int   H_BP      = vga_pkg::DEF_H_BP,
  parameter int   V_ACTIVE  = vga_pkg::DEF_V_ACTIVE,
  parameter int   V_FP      = vga_pkg::DEF_V_FP,
  parameter int   V_SYNC    = vga_pkg::DEF_V_SYNC,
  parameter int   V_BP      = vga_pkg::DEF_V_BP,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   PXL_SCALE = 8,
  parameter int   FB_AW     = vga_pkg::FB_AW
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output logic [FB_AW-1:0]  o_fbAddr,
  input  logic [11:0]       i_fbData,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              i_testPat,
`endif
  output vga_pkg::vga_out_t o_vgaData,
  output logic              o_active,
  output logic              o_frameStart
);
  import vga_pkg::*;

  localparam int SCALE_SH = $clog2(PXL_SCALE);
  localparam int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          vis;
  logic          hs;
  logic          vs;
  logic          fs;
  logic          vis_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic          fs_d1;
  rgb_t          pix;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .vis   (vis),
    .hs    (hs),
    .vs    (vs),
    .fs    (fs)
  );

  // Row-major framebuffer, one word per PXL_SCALE x PXL_SCALE block; blanking parks on 0.
  assign o_fbAddr = vis
    ? FB_AW'((int'(vcnt) >> SCALE_SH) * (H_ACTIVE / PXL_SCALE) + (int'(hcnt) >> SCALE_SH))
    : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vis_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      fs_d1  <= 1'b0;
    end else begin
      vis_d1 <= vis;
      hs_d1  <= hs;
      vs_d1  <= vs;
      fs_d1  <= fs;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_d1;

  // Bar index travels with the S1 flags so it lines up with the output pixel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bar_d1 <= 3'd0;
    end else begin
      bar_d1 <= 3'(int'(hcnt) / BAR_W);
    end
  end

  always_comb begin
    pix = rgb_t'(i_fbData);
    if (i_testPat) begin
      pix = bar_colour(bar_d1);
    end
  end
`else
  assign pix = rgb_t'(i_fbData);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_vgaData.hsync <= ~SYNC_POL;
      o_vgaData.vsync <= ~SYNC_POL;
      o_vgaData.rgb   <= '0;
      o_active        <= 1'b0;
      o_frameStart    <= 1'b0;
    end else begin
      o_vgaData.hsync <= hs_d1 ? SYNC_POL : ~SYNC_POL;
      o_vgaData.vsync <= vs_d1 ? SYNC_POL : ~SYNC_POL;
      o_vgaData.rgb   <= vis_d1 ? pix : '0;
      o_active        <= vis_d1;
      o_frameStart    <= fs_d1;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench: a default-timing instance and a shrunken, active-high-sync
// instance run side by side against a raster model driven by the bench's own clock count.
module tb_vga_scanout;

  typedef struct packed {
    int   ha;
    int   hf;
    int   hs;
    int   hb;
    int   va;
    int   vf;
    int   vs;
    int   vb;
    int   sc;
    logic pol;
  } cfg_t;

  localparam cfg_t FULL  = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, sc: 8, pol: 1'b0};
  localparam cfg_t SMALL = '{ha: 64, hf: 4, hs: 8, hb: 4, va: 16, vf: 2, vs: 2, vb: 3, sc: 8, pol: 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_pat = 1'b0;
  logic tp_edge = 1'b0;
  logic [12:0] addr_f;
  logic [12:0] addr_s;
  logic [11:0] fbd_f = '0;
  logic [11:0] fbd_s = '0;
  vga_pkg::vga_out_t vga_f;
  vga_pkg::vga_out_t vga_s;
  logic act_f;
  logic act_s;
  logic fs_f;
  logic fs_s;
  int n = 0;
  int run = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_scanout dut_full (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .o_fbAddr     (addr_f),
    .i_fbData     (fbd_f),
`ifdef VGA_TEST_PATTERN_EN
    .i_testPat    (test_pat),
`endif
    .o_vgaData    (vga_f),
    .o_active     (act_f),
    .o_frameStart (fs_f)
  );

  vga_scanout #(
    .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (16), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1), .PXL_SCALE (8), .FB_AW (13)
  ) dut_small (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .o_fbAddr     (addr_s),
    .i_fbData     (fbd_s),
`ifdef VGA_TEST_PATTERN_EN
    .i_testPat    (test_pat),
`endif
    .o_vgaData    (vga_s),
    .o_active     (act_s),
    .o_frameStart (fs_s)
  );

  // Framebuffer stand-in: each word holds its own address, returned one clock late.
  always @(posedge clk) begin
    fbd_f   <= addr_f[11:0];
    fbd_s   <= addr_s[11:0];
    tp_edge <= test_pat;
  end

  // Clock edges seen since reset release; counter position equals n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [12:0] model_addr(input cfg_t c, input int p);
    int ht;
    int vt;
    int x;
    int y;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    x = p % ht;
    y = (p / ht) % vt;
    if (x < c.ha && y < c.va) return 13'((y / c.sc) * (c.ha / c.sc) + x / c.sc);
    return 13'd0;
  endfunction

  function automatic logic [11:0] bar_table(input int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Returns {frameStart, active, hsync, vsync, rgb} for the pixel shown after k edges.
  function automatic logic [15:0] model_out(input cfg_t c, input int k, input logic tp);
    int ht;
    int vt;
    int p;
    int x;
    int y;
    logic vis;
    logic hsa;
    logic vsa;
    logic [11:0] rgb;
    logic [12:0] a;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (k < 2) return {2'b00, ~c.pol, ~c.pol, 12'h000};
    p = k - 2;
    x = p % ht;
    y = (p / ht) % vt;
    vis = (x < c.ha) && (y < c.va);
    hsa = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
    vsa = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
    rgb = 12'h000;
    if (vis) begin
      if (tp) begin
        rgb = bar_table(x / (c.ha / 8));
      end else begin
        a = model_addr(c, p);
        rgb = a[11:0];
      end
    end
    return {(x == 0 && y == 0), vis, (hsa ? c.pol : ~c.pol), (vsa ? c.pol : ~c.pol), rgb};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d t=%0t: got %0h, expected %0h", name, n, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input cfg_t c, input logic [12:0] addr,
                           input vga_pkg::vga_out_t v, input logic a, input logic f);
    logic [15:0] e;
    e = model_out(c, n, tp_edge);
    check_output({tag, " vga"}, 32'(v), 32'(e[13:0]));
    check_output({tag, " active"}, 32'(a), 32'(e[14]));
    check_output({tag, " frameStart"}, 32'(f), 32'(e[15]));
    check_output({tag, " fbAddr"}, 32'(addr), 32'(model_addr(c, n)));
  endtask

  // Every cycle: both instances against the model, plus hand-computed anchor points.
  always @(negedge clk) begin
    check_dut("full", FULL, addr_f, vga_f, act_f, fs_f);
    check_dut("small", SMALL, addr_s, vga_s, act_s, fs_s);
    if (rst_n) begin
      if (n == 60)   check_output("lit full addr(60,0)", 32'(addr_f), 32'd7);
      if (n == 6400) check_output("lit full addr(0,8)", 32'(addr_f), 32'd80);
      if (n == 657)  check_output("lit full hsync x655", 32'(vga_f.hsync), 32'd1);
      if (n == 658)  check_output("lit full hsync x656", 32'(vga_f.hsync), 32'd0);
      if (n == 753)  check_output("lit full hsync x751", 32'(vga_f.hsync), 32'd0);
      if (n == 754)  check_output("lit full hsync x752", 32'(vga_f.hsync), 32'd1);
      if (n == 2) begin
        check_output("lit full frameStart first", 32'(fs_f), 32'd1);
        check_output("lit full active first", 32'(act_f), 32'd1);
        check_output("lit full rgb first", 32'(vga_f.rgb), 32'h000);
      end
      if (n == 10)   check_output("lit full rgb x8", 32'(vga_f.rgb), 32'h001);
      if (n == 642) begin
        check_output("lit full active x640", 32'(act_f), 32'd0);
        check_output("lit full rgb x640", 32'(vga_f.rgb), 32'h000);
      end
      if (n == 6402) check_output("lit full rgb (0,8)", 32'(vga_f.rgb), 32'h050);
      if (n == 1441) check_output("lit small vsync line17", 32'(vga_s.vsync), 32'd0);
      if (n == 1442) check_output("lit small vsync line18", 32'(vga_s.vsync), 32'd1);
      if (n == 1842) check_output("lit small frameStart frame2", 32'(fs_s), 32'd1);
      if (n == 1263) check_output("lit small addr last", 32'(addr_s), 32'd15);
      if (run == 1 && n == 1265) check_output("lit small rgb last", 32'(vga_s.rgb), 32'h00F);
`ifdef VGA_TEST_PATTERN_EN
      if (run == 2 && n == 802)  check_output("lit bar x0", 32'(vga_f.rgb), 32'hFFF);
      if (run == 2 && n == 882)  check_output("lit bar x80", 32'(vga_f.rgb), 32'hFF0);
      if (run == 2 && n == 1402) check_output("lit bar x600", 32'(vga_f.rgb), 32'h000);
      if (run == 2 && n == 882)  check_output("lit bar hsync", 32'(vga_f.hsync), 32'd1);
`endif
    end
  end

  initial begin
    run = 1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Small raster sits at (30,10) of its third frame here.
    repeat (4510) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_output("async rst full vga", 32'(vga_f), 32'h3000);
    check_output("async rst small vga", 32'(vga_s), 32'h0000);
    check_output("async rst full active", 32'(act_f), 32'd0);
    check_output("async rst small frameStart", 32'(fs_s), 32'd0);
    check_output("async rst full addr", 32'(addr_f), 32'd0);

    repeat (3) @(posedge clk);
    run = 2;
    #3 rst_n = 1'b1;
    repeat (790) @(posedge clk);
`ifdef VGA_TEST_PATTERN_EN
    #3 test_pat = 1'b1;
`endif
    repeat (910) @(posedge clk);
    #3 test_pat = 1'b0;
    repeat (6500) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
